// File: rtl/tl_phase_sched.sv
// tl_phase_sched: traffic-light phase scheduler with 1 s prescaler, request latches
// and min/max green timing; chrtsw is decoded straight from the phase register.
module tl_phase_sched #(
   parameter int TICK_DIV = 50_000_000,
   parameter int MIN_GRN  = 5,
   parameter int MAX_GRN  = 20,
   parameter int CHG_SEC  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       hold,
   output logic       sec,
   output logic       chrtsw,
   output logic [1:0] phase,
   output logic       pend0,
   output logic       pend1,
   output logic [4:0] tsec
);
   localparam int PW = $clog2(TICK_DIV);
   typedef enum logic [1:0] {GRN0 = 2'b00, CHG01 = 2'b01, CHG10 = 2'b10, GRN1 = 2'b11} phase_t;
   phase_t        phase_q, phase_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [4:0]    tsec_q, tsec_d;
   logic          pend0_q, pend0_d, pend1_q, pend1_d;
   always_comb begin
      sec     = pcnt_q == PW'(TICK_DIV - 1);
      pcnt_d  = sec ? '0 : pcnt_q + 1'b1;
      phase_d = phase_q;
      case (phase_q)
         GRN0:    phase_d = (!hold && ((tsec_q >= 5'(MIN_GRN) && pend1_q) || tsec_q >= 5'(MAX_GRN))) ? CHG01 : GRN0;
         CHG01:   phase_d = (tsec_q == 5'(CHG_SEC + 1)) ? GRN1 : CHG01;
         GRN1:    phase_d = (!hold && ((tsec_q >= 5'(MIN_GRN) && pend0_q) || tsec_q >= 5'(MAX_GRN))) ? CHG10 : GRN1;
         default: phase_d = (tsec_q == 5'(CHG_SEC + 1)) ? GRN0 : CHG10;
      endcase
      tsec_d  = (phase_d != phase_q) ? 5'd0 : (sec && tsec_q != 5'd31) ? tsec_q + 5'd1 : tsec_q;
      // entering a way's green clears its flag even if a request arrives on the same edge
      pend0_d = (phase_d == GRN0 && phase_q != GRN0) ? 1'b0 : pend0_q | (req0 && phase_q != GRN0);
      pend1_d = (phase_d == GRN1 && phase_q != GRN1) ? 1'b0 : pend1_q | (req1 && phase_q != GRN1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_q <= GRN0;
         pcnt_q  <= '0;
         tsec_q  <= '0;
         pend0_q <= 1'b0;
         pend1_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         pcnt_q  <= pcnt_d;
         tsec_q  <= tsec_d;
         pend0_q <= pend0_d;
         pend1_q <= pend1_d;
      end
   end
   assign phase  = phase_q;
   assign chrtsw = ~phase_q[0];
   assign tsec   = tsec_q;
   assign pend0  = pend0_q;
   assign pend1  = pend1_q;
endmodule

// File: tb/tb_tl_phase_sched.sv
// tb_tl_phase_sched: directed bench; expected phase sequence is queued as stimulus is applied
// and popped whenever the DUT changes phase.
module tb_tl_phase_sched;
   logic       clk = 1'b0, rst = 1'b1, req0 = 1'b0, req1 = 1'b0, hold = 1'b0;
   logic       sec, chrtsw, pend0, pend1;
   logic [1:0] phase;
   logic [4:0] tsec;
   logic       rst_b = 1'b1, req0_b = 1'b0, req1_b = 1'b0, hold_b = 1'b0;
   logic       sec_b, chrtsw_b, pend0_b, pend1_b;
   logic [1:0] phase_b;
   logic [4:0] tsec_b;
   int         n_chk = 0, n_err = 0;
   int         ph_q[$];
   logic [1:0] ph_prev = 2'b00;

   tl_phase_sched #(.TICK_DIV(4), .MIN_GRN(2), .MAX_GRN(6), .CHG_SEC(3)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .hold(hold), .sec(sec),
      .chrtsw(chrtsw), .phase(phase), .pend0(pend0), .pend1(pend1), .tsec(tsec));
   tl_phase_sched #(.TICK_DIV(4), .MIN_GRN(2), .MAX_GRN(31), .CHG_SEC(3)) dut_b (
      .clk(clk), .rst(rst_b), .req0(req0_b), .req1(req1_b), .hold(hold_b), .sec(sec_b),
      .chrtsw(chrtsw_b), .phase(phase_b), .pend0(pend0_b), .pend1(pend1_b), .tsec(tsec_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // advance to the next falling edge; any phase change is compared against the queued expectation
   task automatic cyc(input int n);
      int e;
      repeat (n) begin
         @(negedge clk);
         if (phase !== ph_prev) begin
            e = (ph_q.size() != 0) ? ph_q.pop_front() : 4;
            chk("phase_seq", 32'(phase), 32'(e));
            ph_prev = phase;
         end
      end
   endtask

   task automatic wait_change(output int n, output int s);
      logic [1:0] p0;
      p0 = phase;
      n = 0;
      s = 0;
      while (phase === p0 && n < 300) begin
         if (sec) s++;
         cyc(1);
         n++;
      end
      chk("wait_bound", 32'(phase !== p0), 32'd1);
   endtask

   initial begin
      int n, s, bad;
      #1;
      chk("rst_sec", 32'(sec), 0);
      chk("rst_phase", 32'(phase), 0);
      chk("rst_chrtsw", 32'(chrtsw), 1);
      chk("rst_tsec", 32'(tsec), 0);
      chk("rst_pend", 32'({pend0, pend1}), 0);
      @(negedge clk);
      rst = 1'b0;
      // early request: req1 at tsec=0, switch after tsec reaches MIN_GRN
      ph_q.push_back(1);
      for (int k = 1; k <= 8; k++) begin
         if (k == 1) req1 = 1'b1;
         cyc(1);
         req1 = 1'b0;
         chk("tick_sec", 32'(sec), 32'(k % 4 == 3));
         if (k == 1) chk("req_pend1", 32'(pend1), 1);
      end
      chk("early_tsec2", 32'(tsec), 2);
      chk("early_still_grn0", 32'(phase), 0);
      cyc(1);
      chk("early_chrtsw", 32'(chrtsw), 0);
      chk("early_tsec_clr", 32'(tsec), 0);
      chk("early_pend1_kept", 32'(pend1), 1);
      ph_q.push_back(3);
      wait_change(n, s);
      chk("chg01_cycles", 32'(n), 16);
      chk("chg01_secs", 32'(s), 4);
      chk("grn1_pend1_clr", 32'(pend1), 0);
      chk("grn1_tsec", 32'(tsec), 0);
      // forced switching with no requests
      ph_q.push_back(2);
      wait_change(n, s);
      chk("grn1_forced_cycles", 32'(n), 24);
      chk("grn1_forced_secs", 32'(s), 6);
      chk("chg10_chrtsw", 32'(chrtsw), 1);
      ph_q.push_back(0);
      wait_change(n, s);
      chk("chg10_cycles", 32'(n), 16);
      // hold in GRN0 with pend1 set
      hold = 1'b1;
      req1 = 1'b1;
      cyc(1);
      req1 = 1'b0;
      chk("hold_pend1", 32'(pend1), 1);
      cyc(140);
      chk("hold_phase", 32'(phase), 0);
      chk("hold_tsec_sat", 32'(tsec), 31);
      cyc(8);
      chk("hold_tsec_stay", 32'(tsec), 31);
      ph_q.push_back(1);
      hold = 1'b0;
      cyc(1);
      chk("unhold_switch", 32'(phase), 1);
      chk("unhold_tsec", 32'(tsec), 0);
      hold = 1'b1;
      ph_q.push_back(3);
      wait_change(n, s);
      chk("hold_in_chg_secs", 32'(s), 4);
      hold = 1'b0;
      ph_q.push_back(2);
      wait_change(n, s);
      ph_q.push_back(0);
      wait_change(n, s);
      // request for the way already green is ignored
      ph_q.push_back(1);
      req0 = 1'b1;
      bad = 0;
      n = 0;
      while (phase === 2'b00 && n < 100) begin
         if (pend0 !== 1'b0) bad = 1;
         if (tsec == 5'd6) req0 = 1'b0;
         cyc(1);
         n++;
      end
      req0 = 1'b0;
      chk("green_req_ignored", 32'(bad), 0);
      chk("green_req_exit", 32'(phase), 1);
      chk("green_req_pend0", 32'(pend0), 0);
      req0 = 1'b1;
      req1 = 1'b1;
      cyc(1);
      req0 = 1'b0;
      req1 = 1'b0;
      chk("both_req", 32'({pend0, pend1}), 3);
      ph_q.push_back(3);
      wait_change(n, s);
      chk("both_pend1_clr", 32'(pend1), 0);
      chk("both_pend0_kept", 32'(pend0), 1);
      // asynchronous reset while sec is high
      n = 0;
      while (sec !== 1'b1 && n < 8) begin
         cyc(1);
         n++;
      end
      chk("sec_seen", 32'(sec), 1);
      #2 rst = 1'b1;
      #1;
      chk("arst_sec", 32'(sec), 0);
      chk("arst_phase", 32'(phase), 0);
      chk("arst_chrtsw", 32'(chrtsw), 1);
      chk("arst_tsec", 32'(tsec), 0);
      chk("arst_pend", 32'({pend0, pend1}), 0);
      ph_q.push_back(0);
      cyc(1);
      // saturation boundary with MAX_GRN = 31
      rst_b = 1'b0;
      cyc(123);
      chk("sat_tsec30", 32'(tsec_b), 30);
      cyc(1);
      chk("sat_tsec31", 32'(tsec_b), 31);
      chk("sat_no_switch_yet", 32'(phase_b), 0);
      cyc(1);
      chk("sat_switch", 32'(phase_b), 1);
      chk("sat_tsec_clr", 32'(tsec_b), 0);
      chk("phase_q_empty", 32'(ph_q.size()), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
